// File: rtl/afifo_pkt_reader_pkg.sv
// Shared types and constants for the packet-framing read stage.
package pkt_reader_pkg;

    // Parser state: waiting for a header word, or streaming payload words.
    typedef enum logic {
        HDR     = 1'b0,
        PAYLOAD = 1'b1
    } state_e;

    // Bit position of the LEN field inside the header word.
    localparam int LEN_LSB = 0;

    // Width of the output-buffer occupancy count (0..2).
    localparam int OCC_W = 2;

endpackage

// File: rtl/afifo_pkt_reader_skid_buf2.sv
// Two-entry in-order buffer with registered occupancy; the head register
// drives the output directly so there is no combinational input-to-output path.
module skid_buf2
    import pkt_reader_pkg::*;
#(
    parameter int W = 33
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [W-1:0]     din_i,
    output logic [OCC_W-1:0] occ_o,
    output logic [W-1:0]     head_o
);

    logic [W-1:0]     head_q, head_d;
    logic [W-1:0]     tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic             do_pop;
    logic             do_push;

    // A pop needs a valid head; a push is only taken when a slot is free
    // or the head is leaving in the same cycle.
    assign do_pop  = pop_i & (occ_q != 2'd0);
    assign do_push = push_i & ((occ_q != 2'd2) | do_pop);

    // Next-state selection of head/tail registers and occupancy.
    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        case (occ_q)
            2'd0: begin
                if (do_push) begin
                    head_d = din_i;
                    occ_d  = 2'd1;
                end
            end
            2'd1: begin
                if (do_push && do_pop) begin
                    head_d = din_i;
                end else if (do_push) begin
                    tail_d = din_i;
                    occ_d  = 2'd2;
                end else if (do_pop) begin
                    occ_d  = 2'd0;
                end
            end
            default: begin
                if (do_pop) begin
                    head_d = tail_q;
                    if (do_push) begin
                        tail_d = din_i;
                    end else begin
                        occ_d  = 2'd1;
                    end
                end
            end
        endcase
    end

    // Buffer registers; reset clears contents so outputs start at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = head_q;

endmodule

// File: rtl/afifo_pkt_reader.sv
// Pops length-prefixed packets from a show-ahead FIFO, drops the header and
// streams the payload through a 2-entry buffer with a last-beat flag.
module afifo_pkt_reader
    import pkt_reader_pkg::*;
#(
    parameter int DW = 32,
    parameter int LW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fifo_empty,
    input  logic [DW-1:0] fifo_data,
    output logic          fifo_rd,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          m_last,
    output logic          pkt_done,
    output logic          zero_len,
    output logic          busy
);

    state_e           state_q;
    logic [LW-1:0]    rem_q;
    logic             zero_len_q;
    logic [LW-1:0]    hdr_len;
    logic [OCC_W-1:0] occ;
    logic             buf_push;
    logic             buf_pop;
    logic [DW:0]      buf_din;
    logic [DW:0]      buf_head;

    assign hdr_len = fifo_data[LEN_LSB +: LW];

    // Headers are always consumable; payload pops wait for a free buffer slot.
    // Deliberately independent of m_ready so the FIFO side never sees a
    // combinational path from the downstream handshake.
    assign fifo_rd = rst_n & ~fifo_empty & ((state_q == HDR) | (occ != 2'd2));

    assign buf_push = fifo_rd & (state_q == PAYLOAD);
    assign buf_pop  = m_valid & m_ready;
    assign buf_din  = {(rem_q == LW'(1)), fifo_data};

    skid_buf2 #(
        .W (DW + 1)
    ) u_buf (
        .clk    (clk),
        .rst_n  (rst_n),
        .push_i (buf_push),
        .pop_i  (buf_pop),
        .din_i  (buf_din),
        .occ_o  (occ),
        .head_o (buf_head)
    );

    // Header/payload parser with remaining-word counter and zero-length pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= HDR;
            rem_q      <= '0;
            zero_len_q <= 1'b0;
        end else begin
            zero_len_q <= 1'b0;
            case (state_q)
                HDR: begin
                    if (fifo_rd) begin
                        if (hdr_len == '0) begin
                            zero_len_q <= 1'b1;
                        end else begin
                            rem_q   <= hdr_len;
                            state_q <= PAYLOAD;
                        end
                    end
                end
                default: begin
                    if (fifo_rd) begin
                        // rem is at least 1 here; the guard keeps it from wrapping.
                        if (rem_q != '0) begin
                            rem_q <= rem_q - LW'(1);
                        end
                        if (rem_q == LW'(1)) begin
                            state_q <= HDR;
                        end
                    end
                end
            endcase
        end
    end

    assign m_valid  = (occ != 2'd0);
    assign m_data   = buf_head[DW-1:0];
    assign m_last   = buf_head[DW];
    assign pkt_done = m_valid & m_ready & m_last;
    assign zero_len = zero_len_q;
    assign busy     = (state_q == PAYLOAD) | (occ != 2'd0);

endmodule

// File: tb/tb_afifo_pkt_reader.sv
// Directed bench for afifo_pkt_reader with a show-ahead FIFO model and a
// scoreboard of expected payload beats.
module tb_afifo_pkt_reader;

    localparam int DW = 32;
    localparam int LW = 16;

    logic          clk;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_data;
    logic          fifo_rd;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          pkt_done;
    logic          zero_len;
    logic          busy;

    logic [DW-1:0] fifo_q[$];
    logic [DW:0]   exp_q[$];
    int            acc_cyc[$];

    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   pkt_cnt  = 0;
    int   zl_cnt   = 0;
    int   pk0;
    int   zl0;
    logic rd_neg    = 1'b0;
    logic starve_en = 1'b0;
    logic starve_ph = 1'b0;

    afifo_pkt_reader #(
        .DW (DW),
        .LW (LW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .pkt_done   (pkt_done),
        .zero_len   (zero_len),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        fifo_empty = (fifo_q.size() == 0) || starve_ph;
        fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
    endfunction

    task automatic load(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        refresh();
    endtask

    task automatic expect_beat(input logic last, input logic [DW-1:0] d);
        exp_q.push_back({last, d});
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || fifo_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_drain"},
              64'((exp_q.size() == 0) && (fifo_q.size() == 0) && !busy), 64'd1);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_valid && n < 20);
        check({tag, "_valid"}, 64'(m_valid), 64'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_m_valid"},  64'(m_valid),  64'd0);
        check({tag, "_m_data"},   64'(m_data),   64'd0);
        check({tag, "_m_last"},   64'(m_last),   64'd0);
        check({tag, "_busy"},     64'(busy),     64'd0);
        check({tag, "_zero_len"}, 64'(zero_len), 64'd0);
        check({tag, "_pkt_done"}, 64'(pkt_done), 64'd0);
        check({tag, "_fifo_rd"},  64'(fifo_rd),  64'd0);
    endtask

    always @(posedge clk) cyc++;

    // FIFO model: a read seen before the edge removes the head just after it.
    always @(posedge clk) begin
        #1;
        if (rd_neg && !fifo_empty && fifo_q.size() != 0) void'(fifo_q.pop_front());
        if (starve_en) starve_ph = ~starve_ph;
        else           starve_ph = 1'b0;
        refresh();
    end

    // Output monitor and scoreboard.
    always @(negedge clk) begin
        rd_neg = fifo_rd;
        if (fifo_rd) check("rd_while_empty", 64'(fifo_empty), 64'd0);
        if (rst_n && m_valid && m_ready) begin
            acc_cyc.push_back(cyc);
            n_assert++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL unexpected_beat: observed %0h expected none", {m_last, m_data});
            end
            if (exp_q.size() != 0) check("beat", 64'({m_last, m_data}), 64'(exp_q.pop_front()));
        end
        if (pkt_done) pkt_cnt++;
        if (zero_len) zl_cnt++;
    end

    initial begin
        rst_n   = 1'b0;
        m_ready = 1'b1;
        refresh();

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_rel");

        // Single packet: header 3, A B C
        @(posedge clk); #2;
        load(32'h3); load(32'hA); load(32'hB); load(32'hC);
        expect_beat(1'b0, 32'hA); expect_beat(1'b0, 32'hB); expect_beat(1'b1, 32'hC);
        pk0 = pkt_cnt;
        @(negedge clk); check("sp_hdr_rd", 64'(fifo_rd), 64'd1);
        @(negedge clk); check("sp_c1_valid", 64'(m_valid), 64'd0);
                        check("sp_c1_busy", 64'(busy), 64'd1);
        @(negedge clk); check("sp_A", 64'({m_valid, m_last, m_data}), {31'd0, 1'b1, 1'b0, 32'hA});
        @(negedge clk); check("sp_B", 64'({m_valid, m_last, m_data}), {31'd0, 1'b1, 1'b0, 32'hB});
        @(negedge clk); check("sp_C", 64'({m_valid, m_last, m_data}), {31'd0, 1'b1, 1'b1, 32'hC});
                        check("sp_pkt_done", 64'(pkt_done), 64'd1);
        @(negedge clk); check("sp_end_valid", 64'(m_valid), 64'd0);
                        check("sp_end_busy", 64'(busy), 64'd0);
        check("sp_pkt_cnt", 64'(pkt_cnt - pk0), 64'd1);

        // Zero length header then LEN=1
        @(posedge clk); #2;
        pk0 = pkt_cnt; zl0 = zl_cnt;
        load(32'h0); load(32'h1); load(32'hD);
        expect_beat(1'b1, 32'hD);
        drain("zl");
        check("zl_pulses", 64'(zl_cnt - zl0), 64'd1);
        check("zl_pkts", 64'(pkt_cnt - pk0), 64'd1);

        // Backpressure: LEN=4, m_ready low for 5 cycles after first beat
        @(posedge clk); #2;
        load(32'h4);
        for (int i = 0; i < 4; i++) begin
            load(32'hE0 + 32'(i));
            expect_beat(i == 3, 32'hE0 + 32'(i));
        end
        wait_valid("bp");
        @(posedge clk); #2;
        m_ready = 1'b0;
        @(negedge clk); check("bp_one_more_rd", 64'(fifo_rd), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_stall_rd", 64'(fifo_rd), 64'd0);
            check("bp_stall_hold", 64'({m_valid, m_last, m_data}), {31'd0, 1'b1, 1'b0, 32'hE1});
        end
        @(posedge clk); #2;
        m_ready = 1'b1;
        drain("bp");

        // Starved FIFO: empty flag toggles every cycle
        @(posedge clk); #2;
        starve_en = 1'b1;
        load(32'h3); load(32'h51); load(32'h52); load(32'h53);
        expect_beat(1'b0, 32'h51); expect_beat(1'b0, 32'h52); expect_beat(1'b1, 32'h53);
        drain("starve");
        starve_en = 1'b0;

        // Back-to-back packets with upper header bits set
        @(posedge clk); #2;
        acc_cyc.delete();
        load(32'hFFFF_0002); load(32'h1111_0001); load(32'h2222_0002);
        load(32'hFFFF_0001); load(32'h3333_0003);
        expect_beat(1'b0, 32'h1111_0001); expect_beat(1'b1, 32'h2222_0002);
        expect_beat(1'b1, 32'h3333_0003);
        drain("b2b");
        check("b2b_beats", 64'(acc_cyc.size()), 64'd3);
        if (acc_cyc.size() == 3) begin
            check("b2b_gap_xy", 64'(acc_cyc[1] - acc_cyc[0]), 64'd1);
            check("b2b_gap_yz", 64'(acc_cyc[2] - acc_cyc[1]), 64'd2);
        end

        // Reset mid-packet: after first of 3 beats; next word must be a header
        @(posedge clk); #2;
        load(32'h3); load(32'h71); load(32'h72); load(32'h0000_0001); load(32'h0000_ABCD);
        expect_beat(1'b0, 32'h71);
        wait_valid("mr");
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("mr_rst");
        check("mr_sb_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        expect_beat(1'b1, 32'h0000_ABCD);
        pk0 = pkt_cnt;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain("mr");
        check("mr_pkts", 64'(pkt_cnt - pk0), 64'd1);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/afifo_pkt_reader.md
# afifo_pkt_reader

Packet-framing read stage that sits directly downstream of the clock-domain-crossing FIFO, in the FIFO's read-clock domain. It pops length-prefixed packets from the FIFO's show-ahead read port, strips the header word, and presents the payload on a registered valid/ready stream with a last-beat flag. A 2-entry output buffer decouples FIFO pops from downstream stalls while sustaining one beat per cycle.

## Interface
- `DW`, 32: data word width; must match the FIFO's DW.
- `LW`, 16: LEN field width, taken from header bits [LW-1:0]; LW <= DW.

- `clk` in 1: read-side clock, the same clock as the FIFO's clk_o.
- `rst_n` in 1: asynchronous, active-low reset.
- `fifo_empty` in 1: FIFO empty flag.
- `fifo_data` in DW: FIFO head word; valid whenever !fifo_empty.
- `fifo_rd` out 1: pop request, connected to the FIFO's r_req.
- `m_valid` out 1: output beat valid.
- `m_ready` in 1: downstream accepts the beat.
- `m_data` out DW: payload word.
- `m_last` out 1: final payload word of the packet.
- `pkt_done` out 1: pulse on acceptance of a last beat.
- `zero_len` out 1: one-cycle pulse when a header with LEN==0 is popped.
- `busy` out 1: a packet is in progress or the output buffer is non-empty.

## Operation
- Packet format: one header word with LEN=hdr[LW-1:0], followed by LEN payload words. Upper header bits are ignored. The header is never forwarded.
- FSM states and transitions:
  - HDR: if !fifo_empty, pop the header.
    - LEN==0: pulse zero_len and stay in HDR.
    - LEN!=0: set rem<=LEN and go to PAYLOAD.
  - PAYLOAD: if !fifo_empty and occ<2, pop the word and write {data, last=(rem==1)} into the buffer; rem<=rem-1. When the pop is made with rem==1, go to HDR.
- fifo_rd is a combinational function of state, registered occupancy and fifo_empty only:
  - fifo_rd = !fifo_empty & (state==HDR | occ<2).
  - fifo_rd never depends on m_ready and is never asserted while fifo_empty.
  - fifo_rd is forced 0 while rst_n is low.
- Output buffer: 2-entry FIFO-ordered buffer with registered occupancy occ ∈ {0,1,2}.
  - m_valid = (occ!=0). m_data and m_last come from the head register.
  - Push and pop in the same cycle leave occ unchanged.
- The header for the next packet may be popped while previous payload is still draining from the buffer.
- rem is LW bits wide and never wraps, because it is decremented only while nonzero.
- pkt_done = m_valid & m_ready & m_last (combinational).
- busy = (state==PAYLOAD) | (occ!=0).
- Reset values: state=HDR, rem=0, occ=0, m_valid=0, m_data=0, m_last=0, zero_len=0, pkt_done=0, busy=0.
- An asserted reset mid-packet discards buffer contents and rem immediately. The next word popped after reset is treated as a header.

## Timing
- Payload pop at cycle N → m_valid=1 with that word at N+1. There is no combinational path from fifo_data to m_data.
- Header pop at N → earliest payload pop at N+1 → earliest m_valid at N+2.
- A LEN==1 packet takes 2 FIFO pops. Back-to-back packets cost exactly 1 bubble cycle per header on the FIFO side.
- Sustained throughput with m_ready held at 1: 1 payload beat/cycle.
- After m_ready deasserts, at most 1 further word is popped (the buffer fills to occ=2), then fifo_rd drops the following cycle.
- zero_len is registered, high for the cycle after the header pop.
- m_data and m_last hold stable while m_valid & !m_ready.

## Structure
- Package `pkt_reader_pkg`:
  - state enum {HDR, PAYLOAD};
  - LEN field LSB constant (0);
  - occupancy width constant (2).
- Sub-module `skid_buf2`, parameterised by width DW+1 (data plus last):
  - inputs: push, pop;
  - outputs: occ, head data;
  - contains the 2 registers, the occ counter and the head/tail selection.
- Top level holds the FSM, the rem counter, fifo_rd generation and the pulse outputs. Expected size is about 150–250 lines of RTL.

## Test plan
- Single packet: FIFO holds header 0x3 followed by A, B, C; m_ready=1 → beats A, B, C on consecutive cycles, m_last only on C, one pkt_done pulse, busy falls the cycle after C is accepted.
- Zero length: headers 0x0, then 0x1 followed by D → zero_len pulses once, then a single beat D with m_last=1; the 0x0 header produces no m_valid.
- Backpressure: LEN=4 with m_ready=0 for 5 cycles mid-packet → occ saturates at 2, fifo_rd=0 while occ=2, no beat lost or duplicated, order preserved.
- Starved FIFO: fifo_empty toggles every cycle during LEN=3 → fifo_rd never asserted with fifo_empty=1; output is 3 beats with last correct.
- Back-to-back: headers 0x2 (X, Y), then 0x1 (Z) with m_ready=1 → X, Y, bubble, Z; upper header bits 0xFFFF0000 are ignored.
- Reset mid-packet: assert rst_n=0 after 1 of 3 beats → all outputs return to their reset values immediately; after release the next FIFO word is parsed as a header.
